pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
//
// PURPOSE
//   Hazard and sequencing controller for the 5-stage pipeline around the execute stage.
//   Detects load-use and flag-use hazards between ID and EX.
//   Generates PC/IF-ID stalls, ID/EX bubbles and IF-ID flushes.
//   Runs the HLT drain sequence that parks the core once the halt instruction has retired.
//
// PARAMETERS
//   REG_W        4   register-number width
//   DRAIN_CYCLES 3   cycles after halt issue before halted asserts (EX, MEM, WB)
//   CNT_W        16  perf-counter width (PIPE_PERF_CNT_EN only)
//
// PORTS
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous, active-low reset
//   id_rr1_reg    in   REG_W  ID source register 1
//   id_rr2_reg    in   REG_W  ID source register 2
//   id_uses_rr1   in   1      ID instruction reads rr1
//   id_uses_rr2   in   1      ID instruction reads rr2
//   id_is_branch  in   1      ID instruction is a conditional branch (reads flags)
//   id_br_taken   in   1      ID branch resolved taken
//   id_halt       in   1      ID instruction is HLT
//   ex_wr_reg     in   REG_W  EX destination register
//   ex_mem_read   in   1      EX instruction is a load
//   ex_flag_en    in   1      EX instruction updates Z/V/N
//   stall_pc      out  1      hold PC
//   stall_ifid    out  1      hold IF/ID register
//   bubble_idex   out  1      load NOP (all control bits 0) into ID/EX
//   flush_ifid    out  1      replace IF/ID contents with NOP
//   halted        out  1      core parked
//   ctrl_state    out  2      FSM state: 0=RUN, 1=DRAIN, 2=HALTED
//
// BEHAVIOUR
//   - State and drain counter are registered. All outputs except halted/ctrl_state are
//     combinational (Mealy) from inputs and state, so they take effect at the same edge.
//   - Reset: state=RUN, drain_cnt=0, halted=0, ctrl_state=0.
//     With all inputs 0, every stall/bubble/flush output is 0.
//   - Register 0 is hardwired zero and never causes a hazard.
//   - hz_ld = ex_mem_read & ex_wr_reg!=0 &
//     ((id_uses_rr1 & id_rr1_reg==ex_wr_reg) | (id_uses_rr2 & id_rr2_reg==ex_wr_reg)).
//   - hz_fl = id_is_branch & ex_flag_en.
//   - RUN:
//     * (hz_ld|hz_fl): stall_pc = stall_ifid = bubble_idex = 1; flush_ifid = 0.
//       The branch/halt in ID is ignored this cycle and re-evaluated next cycle.
//     * else if id_br_taken: flush_ifid = 1 (one cycle).
//     * else if id_halt: HLT issues to EX this edge.
//       Next state DRAIN, drain_cnt <= DRAIN_CYCLES-1; stall_pc = stall_ifid = 1.
//     * Priority: hazard stall > branch flush > halt.
//   - DRAIN: stall_pc = stall_ifid = bubble_idex = 1, flush_ifid = 0. Hazard inputs ignored.
//     drain_cnt decrements each cycle; at drain_cnt==0, next state HALTED.
//   - HALTED: stall_pc = stall_ifid = bubble_idex = 1, halted = 1.
//     Exit only via rst_n.
//   - Halt latency: halted rises exactly DRAIN_CYCLES+1 edges after the RUN cycle
//     with id_halt=1 and no hazard.
//   - Reset asserted mid-DRAIN or in HALTED: immediate return to RUN, counter cleared.
//   - Consecutive stalls are unbounded; the controller holds as long as the hazard persists.
//
// CONFIGURATION
//   PIPE_PERF_CNT_EN defined:
//     * Adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], reset to 0.
//     * stall_cnt +1 on each RUN cycle with a hazard stall.
//     * flush_cnt +1 on each flush_ifid cycle.
//     * Both saturate at all-ones and are frozen in DRAIN/HALTED.
//   Not defined: counter ports and logic absent; all other behaviour identical.
//
// TESTING
//   1. Load-use: ex_mem_read=1, ex_wr_reg=5, id_rr1_reg=5, id_uses_rr1=1
//      -> stall_pc = stall_ifid = bubble_idex = 1 that cycle.
//      ex_mem_read=0 next cycle -> all outputs 0.
//   2. R0 guard: same as test 1 but ex_wr_reg=0, or id_uses_rr1=0 -> no stall.
//   3. Flag hazard with branch: id_is_branch=1, id_br_taken=1, ex_flag_en=1 -> stall, flush_ifid=0.
//      Next cycle ex_flag_en=0 -> flush_ifid=1 for one cycle.
//   4. Halt drain, DRAIN_CYCLES=3: id_halt=1 in RUN -> ctrl_state 0->1 for 3 cycles, then 2.
//      halted=1 on the 4th edge; stalls stay high thereafter.
//   5. Reset mid-DRAIN: rst_n low on the 2nd DRAIN cycle -> ctrl_state=0, halted=0, all outputs 0
//      asynchronously. After release, a load-use hazard stalls normally.
//   6. PIPE_PERF_CNT_EN: 3 load-use stalls + 2 taken branches -> stall_cnt=3, flush_cnt=2.
//      Force both counters near all-ones -> they saturate and do not wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID/EX hazard detection, stall/flush generation and HLT drain sequencing
//
// Optional feature macro: PIPE_PERF_CNT_EN (adds saturating stall/flush counters)
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   id_rr1_reg, id_rr2_reg      ID source registers
//   id_uses_rr1, id_uses_rr2    ID instruction reads the corresponding source
//   id_is_branch, id_br_taken   ID conditional branch (reads flags) and its resolution
//   id_halt                     ID instruction is HLT
//   ex_wr_reg, ex_mem_read      EX destination register, EX is a load
//   ex_flag_en                  EX instruction updates Z/V/N
//   stall_pc, stall_ifid        hold PC / IF-ID
//   bubble_idex, flush_ifid     NOP into ID/EX / replace IF-ID with NOP
//   halted, ctrl_state          core parked, FSM state (0=RUN 1=DRAIN 2=HALTED)
//   stall_cnt, flush_cnt        perf counters (PIPE_PERF_CNT_EN only)
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rr1_reg,
  input  logic [REG_W-1:0] id_rr2_reg,
  input  logic             id_uses_rr1,
  input  logic             id_uses_rr2,
  input  logic             id_is_branch,
  input  logic             id_br_taken,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic             ex_mem_read,
  input  logic             ex_flag_en,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             halted,
  output logic [1:0]       ctrl_state
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] drain_cnt, drain_cnt_nx;
  logic          hz_ld, hz_fl, hazard;

  // Register 0 is hardwired zero, so a load targeting it can never create a dependency.
  assign hz_ld = ex_mem_read && (ex_wr_reg != '0) &&
                 ((id_uses_rr1 && (id_rr1_reg == ex_wr_reg)) ||
                  (id_uses_rr2 && (id_rr2_reg == ex_wr_reg)));
  assign hz_fl  = id_is_branch && ex_flag_en;
  assign hazard = hz_ld || hz_fl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    case (state)
      S_RUN: begin
        if (hazard) begin
          // Branch/halt in ID waits; it is re-evaluated once the hazard clears.
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (id_br_taken) begin
          flush_ifid = 1'b1;
        end else if (id_halt) begin
          // HLT itself moves into EX this edge; only fetch is frozen.
          state_nx     = S_DRAIN;
          drain_cnt_nx = DW'(DRAIN_CYCLES - 1);
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
        end
      end
      S_DRAIN: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
        if (drain_cnt == '0) state_nx = S_HALTED;
        else                 drain_cnt_nx = drain_cnt - DW'(1);
      end
      S_HALTED: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      default: begin
        state_nx     = S_RUN;
        drain_cnt_nx = '0;
      end
    endcase
  end

  assign halted     = (state == S_HALTED);
  assign ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, flush_inc;

  // Only RUN produces these events, so the counters freeze in DRAIN/HALTED.
  assign stall_inc = (state == S_RUN) && hazard;
  assign flush_inc = flush_ifid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
